bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Parametrised N-digit BCD counter with a built-in prescaler, up/down direction, enable, synchronous clear and parallel load. Successor to the fixed 4-digit up-only display counter. Feeds the per-digit 7-segment decoders and exposes a tick and a wrap/borrow pulse for cascading or event logging. Single clock domain.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is the least significant.
TICK_DIV, 10000000, clock cycles per count step (>=1); 1 means a step on every enabled cycle.
DIV_W, $clog2(TICK_DIV) (minimum 1), prescaler width; derived, not overridden.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_en  in  1  count enable; low freezes the prescaler and the digits
i_up  in  1  direction; 1 = increment, 0 = decrement; sampled on each step
i_clear  in  1  synchronous clear of the digits and the prescaler
i_load  in  1  synchronous parallel load
i_load_val  in  4*NUM_DIGITS  load value; digit k is at [4k+3:4k]
o_digits  out  4*NUM_DIGITS  current BCD value; same packing as i_load_val
o_tick  out  1  one-cycle pulse, coincident with each step's new value
o_wrap  out  1  one-cycle pulse on rollover (up: all-9 -> all-0; down: all-0 -> all-9)

Behaviour:
- Reset (async assert, sync release): o_digits = 0, prescaler = 0, o_tick = 0, o_wrap = 0.
- Priority per edge: i_rst > i_clear > i_load > step.
- i_clear: digits = 0, prescaler = 0, o_tick = 0, o_wrap = 0. Takes effect regardless of i_en.
- i_load: digits = i_load_val, prescaler = 0, no tick and no wrap. Any load digit > 9 is clamped to 9. Takes effect regardless of i_en.
- Prescaler: when i_en = 1, it counts 0..TICK_DIV-1 and then returns to 0. A step occurs on the edge where prescaler == TICK_DIV-1. When i_en = 0, the prescaler holds and no step occurs.
- Up step: digit 0 increments. A digit equal to 9 becomes 0 and carries into the next digit. Carry out of the top digit asserts o_wrap for one cycle.
- Down step: digit 0 decrements. A digit equal to 0 becomes 9 and borrows from the next digit. Borrow out of the top digit asserts o_wrap for one cycle.
- All ripple logic is combinational within one cycle. The registered o_digits holds the new value in the same cycle o_tick = 1 (latency: one edge after the terminal prescaler count is reached).
- Toggling i_up between steps affects only the next step; the prescaler phase is unaffected.
- Deasserting i_en mid-period keeps the prescaler phase; counting resumes where it left off.
- o_tick and o_wrap are registered and are 0 on every cycle without a step.
- Reset asserted mid-period clears everything immediately, without waiting for a clock edge.

Optional Feature:
Macro BCD_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping. An up step at all-9 holds all-9; a down step at all-0 holds all-0. o_tick still pulses, o_wrap stays 0, and an extra output o_sat (1 bit) is high while the value equals the saturation bound in the current direction.
- Undefined: wrap behaviour as above; the o_sat port does not exist.

Test Plan:
- NUM_DIGITS=4, TICK_DIV=4, reset, i_en=1, i_up=1 for 40 cycles -> o_digits=0x0010 after the 10th tick; o_tick every 4th cycle; o_wrap never asserted.
- Load 0x9998, i_up=1, 2 steps -> 0x9999, then 0x0000 with o_wrap=1 for exactly one cycle, coincident with o_tick.
- Load 0x0001, i_up=0, 2 steps -> 0x0000, then 0x9999 with o_wrap=1. Load 0x1000 then 1 down step -> 0x0999.
- Load 0xAF3C (invalid digits) -> o_digits=0x9939. Assert i_clear and i_load in the same cycle -> 0x0000 (clear wins).
- TICK_DIV=4: drop i_en at prescaler=2 for 5 cycles, then restore -> next tick arrives 2 enabled cycles later. Assert i_rst between clock edges -> o_digits=0 immediately.
- With BCD_COUNTER_SAT_EN: at 0x9999 an up step -> stays 0x9999, o_wrap=0, o_sat=1. Switch i_up=0 -> o_sat=0; the next step gives 0x9998.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with prescaler, clear and load.
// Optional build macro BCD_COUNTER_SAT_EN: saturate at all-9/all-0 instead of
// wrapping, and expose o_sat.
module bcd_updown_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 10000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_up,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_val,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_tick,
  output logic                    o_wrap
`ifdef BCD_COUNTER_SAT_EN
  ,
  output logic                    o_sat
`endif
);

  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIG_W-1:0] digits_q;
  logic [DIG_W-1:0] step_digits_c;
  logic [DIG_W-1:0] load_digits_c;
  logic             at_bound_c;
  logic             step_c;
  logic             tick_q;
  logic             wrap_q;

  assign step_c = i_en && (div_q == DIV_LAST);

  // Prescaler next value: free-runs while enabled, holds phase otherwise.
  always_comb begin
    div_d = div_q;
    if (i_en) begin
      div_d = step_c ? '0 : div_q + DIV_W'(1);
    end
  end

  // Digit ripple: carry/borrow propagates while digits sit at the bound.
  // A carry surviving past the top digit means the whole value is at the bound.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    carry         = 1'b1;
    d             = 4'd0;
    step_digits_c = digits_q;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      d = digits_q[4*k +: 4];
      if (carry) begin
        if (i_up) begin
          if (d >= 4'd9) begin
            step_digits_c[4*k +: 4] = 4'd0;
          end else begin
            step_digits_c[4*k +: 4] = d + 4'd1;
            carry                   = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_digits_c[4*k +: 4] = 4'd9;
          end else begin
            step_digits_c[4*k +: 4] = d - 4'd1;
            carry                   = 1'b0;
          end
        end
      end
    end
    at_bound_c = carry;
`ifdef BCD_COUNTER_SAT_EN
    if (carry) begin
      step_digits_c = digits_q;
    end
`endif
  end

  // Load value with any non-decimal digit clamped to 9.
  always_comb begin
    load_digits_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      load_digits_c[4*k +: 4] = (i_load_val[4*k +: 4] > 4'd9) ? 4'd9 : i_load_val[4*k +: 4];
    end
  end

  // State update in priority order: reset, clear, load, step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      digits_q <= '0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (i_clear) begin
      digits_q <= '0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (i_load) begin
      digits_q <= load_digits_c;
      div_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= step_c;
`ifdef BCD_COUNTER_SAT_EN
      wrap_q <= 1'b0;
`else
      wrap_q <= step_c & at_bound_c;
`endif
      if (step_c) begin
        digits_q <= step_digits_c;
      end
    end
  end

  assign o_digits = digits_q;
  assign o_tick   = tick_q;
  assign o_wrap   = wrap_q;
`ifdef BCD_COUNTER_SAT_EN
  // Follows i_up immediately so a direction change is visible at once.
  assign o_sat    = at_bound_c;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed, table-driven bench for bcd_updown_counter (NUM_DIGITS=4, TICK_DIV=4).
module tb_bcd_updown_counter;

`ifdef BCD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] ld_val = 16'h0;
  logic [15:0] digits;
  logic        tick;
  logic        wrap;
`ifdef BCD_COUNTER_SAT_EN
  logic        sat;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  bcd_updown_counter #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up       (up),
    .i_clear    (clr),
    .i_load     (ld),
    .i_load_val (ld_val),
    .o_digits   (digits),
    .o_tick     (tick),
    .o_wrap     (wrap)
`ifdef BCD_COUNTER_SAT_EN
    ,
    .o_sat      (sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic        up;
    logic        clr;
    logic        ld;
    logic [15:0] val;
    int          n;
    logic [15:0] exp_d;
    logic        exp_t;
    logic        exp_w;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input string name, input logic e, input logic u, input logic c,
                              input logic l, input logic [15:0] v, input int n,
                              input logic [15:0] ed, input logic et, input logic ew);
    vec_t r;
    r.name = name; r.en = e; r.up = u; r.clr = c; r.ld = l; r.val = v; r.n = n;
    r.exp_d = ed; r.exp_t = et; r.exp_w = ew;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v);
    en = v.en; up = v.up; clr = v.clr; ld = v.ld; ld_val = v.val;
    repeat (v.n) begin
      @(posedge clk);
      #1;
      clr = 1'b0; ld = 1'b0;
    end
    check({v.name, ".digits"}, 32'(digits), 32'(v.exp_d));
    check({v.name, ".tick"}, 32'(tick), 32'(v.exp_t));
    check({v.name, ".wrap"}, 32'(wrap), 32'(v.exp_w));
  endtask

  initial begin
    vecs[0]  = mk("load_9998",    0, 1, 0, 1, 16'h9998, 1, 16'h9998, 0, 0);
    vecs[1]  = mk("up_pre3",      1, 1, 0, 0, 16'h0,    3, 16'h9998, 0, 0);
    vecs[2]  = mk("up_9999",      1, 1, 0, 0, 16'h0,    1, 16'h9999, 1, 0);
    vecs[3]  = mk("up_pre3b",     1, 1, 0, 0, 16'h0,    3, 16'h9999, 0, 0);
    vecs[4]  = mk("up_wrap",      1, 1, 0, 0, 16'h0,    1, SAT ? 16'h9999 : 16'h0000, 1, !SAT);
    vecs[5]  = mk("wrap_1cyc",    1, 1, 0, 0, 16'h0,    1, SAT ? 16'h9999 : 16'h0000, 0, 0);
    vecs[6]  = mk("load_0001",    1, 0, 0, 1, 16'h0001, 1, 16'h0001, 0, 0);
    vecs[7]  = mk("dn_0000",      1, 0, 0, 0, 16'h0,    4, 16'h0000, 1, 0);
    vecs[8]  = mk("dn_borrow",    1, 0, 0, 0, 16'h0,    4, SAT ? 16'h0000 : 16'h9999, 1, !SAT);
    vecs[9]  = mk("borrow_1cyc",  1, 0, 0, 0, 16'h0,    1, SAT ? 16'h0000 : 16'h9999, 0, 0);
    vecs[10] = mk("load_1000",    1, 0, 0, 1, 16'h1000, 1, 16'h1000, 0, 0);
    vecs[11] = mk("dn_0999",      1, 0, 0, 0, 16'h0,    4, 16'h0999, 1, 0);
    vecs[12] = mk("load_clamp",   1, 0, 0, 1, 16'hAF3C, 1, 16'h9939, 0, 0);
    vecs[13] = mk("clear_wins",   1, 1, 1, 1, 16'h1234, 1, 16'h0000, 0, 0);
    vecs[14] = mk("en_pre2",      1, 1, 0, 0, 16'h0,    2, 16'h0000, 0, 0);
    vecs[15] = mk("en_off_hold",  0, 1, 0, 0, 16'h0,    5, 16'h0000, 0, 0);
    vecs[16] = mk("en_resume1",   1, 1, 0, 0, 16'h0,    1, 16'h0000, 0, 0);
    vecs[17] = mk("en_resume2",   1, 1, 0, 0, 16'h0,    1, 16'h0001, 1, 0);
    vecs[18] = mk("load_en_off",  0, 1, 0, 1, 16'h0012, 1, 16'h0012, 0, 0);
    vecs[19] = mk("clear_en_off", 0, 1, 1, 0, 16'h0,    1, 16'h0000, 0, 0);

    // Reset state while reset is held.
    #12;
    check("rst.digits", 32'(digits), 32'h0);
    check("rst.tick", 32'(tick), 32'h0);
    check("rst.wrap", 32'(wrap), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // 40 enabled up cycles from zero: tick every 4th edge, never a wrap.
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("run40.tick%0d", i), 32'(tick), 32'((i % 4) == 0));
      check($sformatf("run40.wrap%0d", i), 32'(wrap), 32'h0);
    end
    check("run40.digits", 32'(digits), 32'h0010);

    // Asynchronous reset between edges takes effect without a clock.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst.digits", 32'(digits), 32'h0);
    check("async_rst.tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

`ifdef BCD_COUNTER_SAT_EN
    run_vec(mk("sat_load", 0, 1, 0, 1, 16'h9999, 1, 16'h9999, 0, 0));
    run_vec(mk("sat_up",   1, 1, 0, 0, 16'h0,    4, 16'h9999, 1, 0));
    check("sat.hi", 32'(sat), 32'h1);
    up = 1'b0;
    #1;
    check("sat.dir_dn", 32'(sat), 32'h0);
    run_vec(mk("sat_dn",   1, 0, 0, 0, 16'h0,    4, 16'h9998, 1, 0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
